// File: rtl/series_arbiter_pkg.sv
// Shared definitions for the series-engine controllers.
//   series_state_e     : controller FSM state encoding
//   SERIES_TMO_DEFAULT : default engine watchdog limit, in cycles
package series_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } series_state_e;

    localparam int SERIES_TMO_DEFAULT = 64;

endpackage

// File: rtl/series_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index served last; the search starts at ptr+1 (mod N)
//   index : first requesting index found after ptr
//   any   : at least one request bit is set
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] index,
    output logic          any
);

    logic [PW-1:0] cand;

    always_comb begin
        index = '0;
        any   = 1'b0;
        cand  = '0;
        // Walk from the farthest candidate back towards ptr+1 so the
        // nearest requester after ptr is the last (winning) assignment.
        for (int k = N; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                index = cand;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/series_arbiter.sv
// Round-robin arbiter sharing one series engine between N requesters.
//   clk, rst            : clock, asynchronous active-low reset
//   req  [N]            : level requests
//   x_in [N*XW]         : packed arguments, requester i at [i*XW +: XW]
//   ack  [N], err [N]   : one-cycle completion / timeout pulse to the granted requester
//   r_out [RW]          : result of the most recent successful run
//   busy                : controller not idle
//   eng_start, eng_x    : engine start pulse and latched argument
//   eng_r, eng_done     : engine result and completion level
module series_arbiter
    import series_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int XW  = 16,
    parameter int RW  = 18,
    parameter int TMO = SERIES_TMO_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*XW-1:0] x_in,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    err,
    output logic [RW-1:0]   r_out,
    output logic            busy,
    output logic            eng_start,
    output logic [XW-1:0]   eng_x,
    input  logic [RW-1:0]   eng_r,
    input  logic            eng_done
);

    localparam int            PW      = (N > 1) ? $clog2(N) : 1;
    localparam int            CW      = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TMO - 1);
    localparam logic [N-1:0]  ONE     = N'(1);

    series_state_e state, state_n;

    logic [PW-1:0] ptr, gnt, pick;
    logic          pick_any;
    logic [XW-1:0] arg;
    logic [CW-1:0] wd;     // WAIT cycle number minus one
    logic [N-1:0]  err_q;
    logic          done_ok;
    logic          do_grant, do_capture, do_timeout, wd_inc;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .index (pick),
        .any   (pick_any)
    );

    // The first WAIT cycle may still see done from the previous run.
    assign done_ok = eng_done && (wd != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n    = state;
        do_grant   = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        wd_inc     = 1'b0;
        eng_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    do_grant = 1'b1;
                    state_n  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_start = 1'b1;
                state_n   = ST_WAIT;
            end
            ST_WAIT: begin
                // A valid done wins over a timeout in the same cycle.
                if (done_ok) begin
                    do_capture = 1'b1;
                    state_n    = ST_DELIVER;
                end else if (wd == WD_LAST) begin
                    do_timeout = 1'b1;
                    state_n    = ST_IDLE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            ST_DELIVER: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= PW'(N - 1);
            gnt   <= '0;
            arg   <= '0;
            wd    <= '0;
            r_out <= '0;
            err_q <= '0;
        end else begin
            err_q <= do_timeout ? (ONE << gnt) : '0;
            if (do_grant) begin
                gnt <= pick;
                arg <= x_in[int'(pick)*XW +: XW];
            end
            if (eng_start)   wd <= '0;
            else if (wd_inc) wd <= wd + CW'(1);
            if (do_capture) r_out <= eng_r;
            // Timeouts leave ptr alone; only a delivered run moves it.
            if (state == ST_DELIVER) ptr <= gnt;
        end
    end

    assign busy  = (state != ST_IDLE);
    assign ack   = (state == ST_DELIVER) ? (ONE << gnt) : '0;
    assign err   = err_q;
    assign eng_x = arg;

endmodule

// File: doc/series_arbiter.md
SERIES_ARBITER -- requirements
Module: series_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters sharing one series engine.
REQ-002 SHALL have parameter XW, default 16, argument width (engine xBus width).
REQ-003 SHALL have parameter RW, default 18, result width (engine rBus width).
REQ-004 SHALL have parameter TMO, default 64, engine watchdog limit in cycles.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  input  N  per-requester level request.
REQ-008 SHALL have port x_in  input  N*XW  packed arguments, requester i at bits [i*XW +: XW].
REQ-009 SHALL have port ack  output  N  one-cycle completion pulse to requester i.
REQ-010 SHALL have port err  output  N  one-cycle timeout pulse to requester i.
REQ-011 SHALL have port r_out  output  RW  result of the most recent successful delivery.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port eng_start  output  1  start pulse to engine.
REQ-014 SHALL have port eng_x  output  XW  engine argument, driven from the latched argument register.
REQ-015 SHALL have port eng_r  input  RW  engine result.
REQ-016 SHALL have port eng_done  input  1  engine completion level.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, DELIVER.
REQ-018 SHALL, in IDLE with any req bit high, grant round-robin starting at index ptr+1 mod N and go to ISSUE; with req all-zero, remain in IDLE.
REQ-019 SHALL, on grant, latch the granted index and that requester's x_in slice into an argument register; later x_in changes have no effect.
REQ-020 SHALL assert eng_start for exactly the one ISSUE cycle, then go to WAIT.
REQ-021 SHALL ignore eng_done during the first WAIT cycle (stale done from the previous run).
REQ-022 SHALL, in WAIT from the second cycle on with eng_done high, latch eng_r into r_out and go to DELIVER.
REQ-023 SHALL count WAIT cycles; on reaching TMO without a valid done, pulse err[granted] and return to IDLE with r_out unchanged.
REQ-024 SHALL, in DELIVER, pulse ack[granted] for one cycle, set ptr to the granted index, and return to IDLE.
REQ-025 SHALL, when timeout and valid done coincide in the same cycle, treat the run as done (ack, no err).
REQ-026 SHALL still deliver ack to a granted requester that dropped req after the grant.
REQ-027 SHALL never assert more than one ack/err bit, and never ack and err together.
REQ-028 SHALL give minimum latency req-high to ack of 3 cycles plus engine latency; grant-to-grant spacing of at least 4 cycles.

Reset
REQ-029 SHALL, on rst low, immediately force IDLE, ptr=N-1 (first grant favours index 0), ack=0, err=0, eng_start=0, r_out=0, argument register=0, watchdog=0, busy=0.
REQ-030 SHALL abandon any run aborted by reset mid-operation without ack or err; the first post-reset grant re-arbitrates from index 0.

Structure
REQ-031 SHALL take the FSM state encoding and the default TMO from a shared package used by all series-engine controllers.
REQ-032 SHALL place round-robin selection in one combinational sub-module rr_pick (inputs req, ptr; outputs index, any).

Verification
REQ-033 SHALL cover single request: req=0001, x=0x1000, engine done after 8 cycles with eng_r=0x0ABCD -> one eng_start, ack=0001, r_out=0x0ABCD.
REQ-034 SHALL cover fairness: req=1111 held -> grant order 0,1,2,3,0; each ack exactly once per round.
REQ-035 SHALL cover timeout: engine never asserts done, req=0100 -> err=0100 exactly TMO cycles into WAIT, r_out unchanged, no ack.
REQ-036 SHALL cover stale done: eng_done held high from the previous run -> not accepted in the first WAIT cycle.
REQ-037 SHALL cover reset mid-WAIT: rst low -> all outputs zero asynchronously, no ack/err; req=0010 after release -> granted index 1.
REQ-038 SHALL cover argument freeze: x_in changed the cycle after grant -> eng_x keeps the latched value until the next grant.
